// File: rtl/axi_fifo_cut.sv
// AXI register slice: one FIFO per channel (depth 0 = wire), outstanding-transaction
// tracking and an isolate/drain FSM. Define AXI_FIFO_CUT_STATS_EN to add the stall counter.

module axi_fifo_cut_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [Width-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [Width-1:0] out_data
);
   generate
      if (Depth == 0) begin : g_bypass
         logic bypass_unused;
         assign bypass_unused = clk_i ^ rst_ni;
         assign out_valid     = in_valid;
         assign in_ready      = out_ready;
         assign out_data      = in_data;
      end else begin : g_fifo
         localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
         localparam int unsigned CntW = $clog2(Depth + 1);
         localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
         localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

         logic [Width-1:0] mem_reg [Depth];
         logic [PtrW-1:0]  wr_ptr_reg, rd_ptr_reg;
         logic [CntW-1:0]  count_reg;
         logic             push, pop;

         // Ready and valid come only from the count register, never from the far side.
         assign in_ready  = (count_reg != FullCnt);
         assign out_valid = (count_reg != '0);
         assign out_data  = mem_reg[rd_ptr_reg];
         assign push      = in_valid && in_ready;
         assign pop       = out_valid && out_ready;

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
               for (int i = 0; i < Depth; i++) mem_reg[i] <= '0;
            end else begin
               if (push) begin
                  mem_reg[wr_ptr_reg] <= in_data;
                  wr_ptr_reg <= (wr_ptr_reg == LastPtr) ? '0 : wr_ptr_reg + 1'b1;
               end
               if (pop) rd_ptr_reg <= (rd_ptr_reg == LastPtr) ? '0 : rd_ptr_reg + 1'b1;
               if (push && !pop)      count_reg <= count_reg + 1'b1;
               else if (pop && !push) count_reg <= count_reg - 1'b1;
            end
         end
      end
   endgenerate
endmodule

module axi_fifo_cut #(
   parameter int unsigned AwDepth = 2,
   parameter int unsigned WDepth  = 2,
   parameter int unsigned BDepth  = 2,
   parameter int unsigned ArDepth = 2,
   parameter int unsigned RDepth  = 2,
   parameter int unsigned MaxTxns = 8,
   parameter int unsigned AwWidth = 8,
   parameter int unsigned WWidth  = 8,
   parameter int unsigned BWidth  = 2,
   parameter int unsigned ArWidth = 8,
   parameter int unsigned RWidth  = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               slv_aw_valid,
   output logic               slv_aw_ready,
   input  logic [AwWidth-1:0] slv_aw_data,
   input  logic               slv_w_valid,
   output logic               slv_w_ready,
   input  logic [WWidth-1:0]  slv_w_data,
   output logic               slv_b_valid,
   input  logic               slv_b_ready,
   output logic [BWidth-1:0]  slv_b_data,
   input  logic               slv_ar_valid,
   output logic               slv_ar_ready,
   input  logic [ArWidth-1:0] slv_ar_data,
   output logic               slv_r_valid,
   input  logic               slv_r_ready,
   output logic [RWidth-1:0]  slv_r_data,
   output logic               slv_r_last,
   output logic               mst_aw_valid,
   input  logic               mst_aw_ready,
   output logic [AwWidth-1:0] mst_aw_data,
   output logic               mst_w_valid,
   input  logic               mst_w_ready,
   output logic [WWidth-1:0]  mst_w_data,
   input  logic               mst_b_valid,
   output logic               mst_b_ready,
   input  logic [BWidth-1:0]  mst_b_data,
   output logic               mst_ar_valid,
   input  logic               mst_ar_ready,
   output logic [ArWidth-1:0] mst_ar_data,
   input  logic               mst_r_valid,
   output logic               mst_r_ready,
   input  logic [RWidth-1:0]  mst_r_data,
   input  logic               mst_r_last,
   input  logic               isolate_i,
   output logic               isolated_o
`ifdef AXI_FIFO_CUT_STATS_EN
   ,
   output logic [31:0]        stall_cnt_o
`endif
);
   localparam int unsigned TxnW = $clog2(MaxTxns + 1);
   localparam logic [TxnW-1:0] MaxCnt = TxnW'(MaxTxns);

   typedef enum logic [1:0] {StRun, StDrain, StIsolated} state_t;

   state_t          state_reg, state_next;
   logic [TxnW-1:0] wr_cnt_reg, wr_cnt_next, rd_cnt_reg, rd_cnt_next;
   logic            aw_allow, ar_allow, aw_fifo_ready, ar_fifo_ready;
   logic            aw_hs, b_hs, ar_hs, r_last_hs;
   logic [RWidth:0] r_out;

   // New address requests only enter while running and below the outstanding limit.
   assign aw_allow     = (state_reg == StRun) && (wr_cnt_reg != MaxCnt);
   assign ar_allow     = (state_reg == StRun) && (rd_cnt_reg != MaxCnt);
   assign slv_aw_ready = aw_fifo_ready && aw_allow;
   assign slv_ar_ready = ar_fifo_ready && ar_allow;
   assign {slv_r_last, slv_r_data} = r_out;

   axi_fifo_cut_fifo #(.Depth(AwDepth), .Width(AwWidth)) u_aw_fifo (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_valid(slv_aw_valid && aw_allow), .in_ready(aw_fifo_ready), .in_data(slv_aw_data),
      .out_valid(mst_aw_valid), .out_ready(mst_aw_ready), .out_data(mst_aw_data));
   axi_fifo_cut_fifo #(.Depth(WDepth), .Width(WWidth)) u_w_fifo (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_valid(slv_w_valid), .in_ready(slv_w_ready), .in_data(slv_w_data),
      .out_valid(mst_w_valid), .out_ready(mst_w_ready), .out_data(mst_w_data));
   axi_fifo_cut_fifo #(.Depth(BDepth), .Width(BWidth)) u_b_fifo (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_valid(mst_b_valid), .in_ready(mst_b_ready), .in_data(mst_b_data),
      .out_valid(slv_b_valid), .out_ready(slv_b_ready), .out_data(slv_b_data));
   axi_fifo_cut_fifo #(.Depth(ArDepth), .Width(ArWidth)) u_ar_fifo (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_valid(slv_ar_valid && ar_allow), .in_ready(ar_fifo_ready), .in_data(slv_ar_data),
      .out_valid(mst_ar_valid), .out_ready(mst_ar_ready), .out_data(mst_ar_data));
   axi_fifo_cut_fifo #(.Depth(RDepth), .Width(RWidth + 1)) u_r_fifo (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_valid(mst_r_valid), .in_ready(mst_r_ready), .in_data({mst_r_last, mst_r_data}),
      .out_valid(slv_r_valid), .out_ready(slv_r_ready), .out_data(r_out));

   assign aw_hs     = slv_aw_valid && slv_aw_ready;
   assign b_hs      = slv_b_valid && slv_b_ready;
   assign ar_hs     = slv_ar_valid && slv_ar_ready;
   assign r_last_hs = slv_r_valid && slv_r_ready && slv_r_last;

   always_comb begin
      wr_cnt_next = wr_cnt_reg;
      rd_cnt_next = rd_cnt_reg;
      if (aw_hs && !b_hs)                             wr_cnt_next = wr_cnt_reg + 1'b1;
      else if (b_hs && !aw_hs && wr_cnt_reg != '0)    wr_cnt_next = wr_cnt_reg - 1'b1;
      if (ar_hs && !r_last_hs)                        rd_cnt_next = rd_cnt_reg + 1'b1;
      else if (r_last_hs && !ar_hs && rd_cnt_reg != '0) rd_cnt_next = rd_cnt_reg - 1'b1;
   end

   // Drain completes on the next-count values so the last response isolates immediately.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         StRun:      if (isolate_i) state_next = StDrain;
         StDrain:    if (!isolate_i) state_next = StRun;
                     else if (wr_cnt_next == '0 && rd_cnt_next == '0) state_next = StIsolated;
         StIsolated: if (!isolate_i) state_next = StRun;
         default:    state_next = StRun;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg  <= StRun;
         wr_cnt_reg <= '0;
         rd_cnt_reg <= '0;
      end else begin
         state_reg  <= state_next;
         wr_cnt_reg <= wr_cnt_next;
         rd_cnt_reg <= rd_cnt_next;
      end
   end

   assign isolated_o = (state_reg == StIsolated);

   // A response with nothing outstanding is a manager-side protocol violation.
   assert property (@(posedge clk_i) disable iff (!rst_ni) !(b_hs && !aw_hs && wr_cnt_reg == '0));
   assert property (@(posedge clk_i) disable iff (!rst_ni) !(r_last_hs && !ar_hs && rd_cnt_reg == '0));

`ifdef AXI_FIFO_CUT_STATS_EN
   logic [31:0] stall_cnt_reg;
   logic        stall;

   assign stall = (slv_aw_valid && !slv_aw_ready) || (slv_w_valid && !slv_w_ready) ||
                  (slv_ar_valid && !slv_ar_ready) || (mst_b_valid && !mst_b_ready) ||
                  (mst_r_valid && !mst_r_ready);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                             stall_cnt_reg <= '0;
      else if (stall && stall_cnt_reg != '1)   stall_cnt_reg <= stall_cnt_reg + 1'b1;
   end

   assign stall_cnt_o = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_axi_fifo_cut.sv
// Directed bench for axi_fifo_cut: instance 0 has WDepth=1/MaxTxns=8,
// instance 1 has WDepth=3/MaxTxns=2; all other depths 2.

module tb_axi_fifo_cut;
   logic clk_i = 1'b0;
   logic rst_n;
   int   checks, failures;

   logic       s_aw_valid [2], s_aw_ready [2], s_w_valid [2], s_w_ready [2];
   logic       s_b_valid [2], s_b_ready [2], s_ar_valid [2], s_ar_ready [2];
   logic       s_r_valid [2], s_r_ready [2], s_r_last [2];
   logic       m_aw_valid [2], m_aw_ready [2], m_w_valid [2], m_w_ready [2];
   logic       m_b_valid [2], m_b_ready [2], m_ar_valid [2], m_ar_ready [2];
   logic       m_r_valid [2], m_r_ready [2], m_r_last [2];
   logic [7:0] s_aw_data [2], s_w_data [2], s_ar_data [2], s_r_data [2];
   logic [7:0] m_aw_data [2], m_w_data [2], m_ar_data [2], m_r_data [2];
   logic [1:0] s_b_data [2], m_b_data [2];
   logic       isolate [2], isolated [2];
`ifdef AXI_FIFO_CUT_STATS_EN
   logic [31:0] stall_cnt [2];
`endif

   always #5 clk_i = ~clk_i;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         axi_fifo_cut #(.WDepth((gi == 0) ? 1 : 3), .MaxTxns((gi == 0) ? 8 : 2)) u_dut (
            .clk_i(clk_i), .rst_ni(rst_n),
            .slv_aw_valid(s_aw_valid[gi]), .slv_aw_ready(s_aw_ready[gi]), .slv_aw_data(s_aw_data[gi]),
            .slv_w_valid(s_w_valid[gi]), .slv_w_ready(s_w_ready[gi]), .slv_w_data(s_w_data[gi]),
            .slv_b_valid(s_b_valid[gi]), .slv_b_ready(s_b_ready[gi]), .slv_b_data(s_b_data[gi]),
            .slv_ar_valid(s_ar_valid[gi]), .slv_ar_ready(s_ar_ready[gi]), .slv_ar_data(s_ar_data[gi]),
            .slv_r_valid(s_r_valid[gi]), .slv_r_ready(s_r_ready[gi]), .slv_r_data(s_r_data[gi]),
            .slv_r_last(s_r_last[gi]),
            .mst_aw_valid(m_aw_valid[gi]), .mst_aw_ready(m_aw_ready[gi]), .mst_aw_data(m_aw_data[gi]),
            .mst_w_valid(m_w_valid[gi]), .mst_w_ready(m_w_ready[gi]), .mst_w_data(m_w_data[gi]),
            .mst_b_valid(m_b_valid[gi]), .mst_b_ready(m_b_ready[gi]), .mst_b_data(m_b_data[gi]),
            .mst_ar_valid(m_ar_valid[gi]), .mst_ar_ready(m_ar_ready[gi]), .mst_ar_data(m_ar_data[gi]),
            .mst_r_valid(m_r_valid[gi]), .mst_r_ready(m_r_ready[gi]), .mst_r_data(m_r_data[gi]),
            .mst_r_last(m_r_last[gi]),
            .isolate_i(isolate[gi]), .isolated_o(isolated[gi])
`ifdef AXI_FIFO_CUT_STATS_EN
            , .stall_cnt_o(stall_cnt[gi])
`endif
         );
      end
   endgenerate

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic idle_all();
      for (int d = 0; d < 2; d++) begin
         s_aw_valid[d] = 0; s_aw_data[d] = '0; s_w_valid[d] = 0; s_w_data[d] = '0;
         s_ar_valid[d] = 0; s_ar_data[d] = '0; s_b_ready[d] = 1; s_r_ready[d] = 1;
         m_aw_ready[d] = 1; m_w_ready[d] = 1; m_ar_ready[d] = 1;
         m_b_valid[d] = 0; m_b_data[d] = '0; m_r_valid[d] = 0; m_r_data[d] = '0; m_r_last[d] = 0;
         isolate[d] = 0;
      end
   endtask

   task automatic do_reset();
      idle_all();
      @(negedge clk_i);
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
   endtask

   task automatic test_reset();
      logic [10:0] got;
      idle_all();
      @(negedge clk_i);
      rst_n = 0;
      #1;
      for (int d = 0; d < 2; d++) begin
         // readies (aw,w,ar,mst b,mst r) must be 1; valids and isolated must be 0
         got = {s_aw_ready[d], s_w_ready[d], s_ar_ready[d], m_b_ready[d], m_r_ready[d],
                m_aw_valid[d], m_w_valid[d], m_ar_valid[d], s_b_valid[d], s_r_valid[d], isolated[d]};
         if (got !== 11'b11111_000000) begin
            $display("FAIL reset_outputs dut=%0d got=%b exp=%b", d, got, 11'b11111_000000);
            failures++;
         end
         checks++;
      end
      tick();
      rst_n = 1;
      tick();
      #1;
      for (int d = 0; d < 2; d++) begin
         if ({s_aw_ready[d], isolated[d], m_aw_valid[d]} !== 3'b100) begin
            $display("FAIL post_reset dut=%0d got=%b exp=100", d, {s_aw_ready[d], isolated[d], m_aw_valid[d]});
            failures++;
         end
         checks++;
      end
      $display("reset: checked both instances");
   endtask

   task automatic test_aw_backpressure();
      do_reset();
      m_aw_ready[0] = 0;
      s_aw_valid[0] = 1; s_aw_data[0] = 8'hA1; #1;
      if (s_aw_ready[0] !== 1'b1) begin $display("FAIL aw_first_ready got=%b exp=1", s_aw_ready[0]); failures++; end
      checks++;
      tick();
      s_aw_data[0] = 8'hA2; #1;
      if (s_aw_ready[0] !== 1'b1) begin $display("FAIL aw_second_ready got=%b exp=1", s_aw_ready[0]); failures++; end
      checks++;
      if (m_aw_valid[0] !== 1'b1 || m_aw_data[0] !== 8'hA1) begin
         $display("FAIL aw_head got=%b/%h exp=1/a1", m_aw_valid[0], m_aw_data[0]); failures++;
      end
      checks++;
      tick();
      s_aw_data[0] = 8'hA3; #1;
      if (s_aw_ready[0] !== 1'b0) begin $display("FAIL aw_full_ready got=%b exp=0", s_aw_ready[0]); failures++; end
      checks++;
      tick();
      m_aw_ready[0] = 1; #1;
      if (s_aw_ready[0] !== 1'b0) begin $display("FAIL aw_full_pop_ready got=%b exp=0", s_aw_ready[0]); failures++; end
      checks++;
      $display("aw: out %h", m_aw_data[0]);
      tick(); #1;
      if (s_aw_ready[0] !== 1'b1 || m_aw_data[0] !== 8'hA2) begin
         $display("FAIL aw_second_out got=%b/%h exp=1/a2", s_aw_ready[0], m_aw_data[0]); failures++;
      end
      checks++;
      $display("aw: out %h", m_aw_data[0]);
      tick();
      s_aw_valid[0] = 0; #1;
      if (m_aw_valid[0] !== 1'b1 || m_aw_data[0] !== 8'hA3) begin
         $display("FAIL aw_third_out got=%b/%h exp=1/a3", m_aw_valid[0], m_aw_data[0]); failures++;
      end
      checks++;
      $display("aw: out %h", m_aw_data[0]);
      tick(); #1;
      if (m_aw_valid[0] !== 1'b0) begin $display("FAIL aw_drained got=%b exp=0", m_aw_valid[0]); failures++; end
      checks++;
   endtask

   task automatic test_w_throughput(input int d, input int exp_cycles);
      int sent, recv, last_c;
      logic [7:0] exp_d;
      do_reset();
      sent = 0; recv = 0; last_c = -1;
      for (int c = 0; c < 20; c++) begin
         if (recv >= 4) break;
         s_w_valid[d] = (sent < 4);
         s_w_data[d]  = 8'h10 + sent[7:0];
         #1;
         if (m_w_valid[d] && m_w_ready[d]) begin
            exp_d = 8'h10 + recv[7:0];
            if (m_w_data[d] !== exp_d) begin
               $display("FAIL w_order dut=%0d got=%h exp=%h", d, m_w_data[d], exp_d); failures++;
            end
            checks++;
            $display("w: dut=%0d cycle=%0d beat %h", d, c, m_w_data[d]);
            recv++;
            last_c = c;
         end
         if (s_w_valid[d] && s_w_ready[d]) sent++;
         tick();
      end
      s_w_valid[d] = 0;
      if (recv != 4) begin $display("FAIL w_beat_count dut=%0d got=%0d exp=4", d, recv); failures++; end
      checks++;
      if (last_c + 1 != exp_cycles) begin
         $display("FAIL w_cycles dut=%0d got=%0d exp=%0d", d, last_c + 1, exp_cycles); failures++;
      end
      checks++;
   endtask

   task automatic test_ar_limit();
      do_reset();
      s_ar_valid[1] = 1; s_ar_data[1] = 8'hB0; #1;
      if (s_ar_ready[1] !== 1'b1) begin $display("FAIL ar_first_ready got=%b exp=1", s_ar_ready[1]); failures++; end
      checks++;
      tick();
      s_ar_data[1] = 8'hB1; #1;
      if (s_ar_ready[1] !== 1'b1 || m_ar_data[1] !== 8'hB0) begin
         $display("FAIL ar_second got=%b/%h exp=1/b0", s_ar_ready[1], m_ar_data[1]); failures++;
      end
      checks++;
      tick();
      s_ar_data[1] = 8'hB2; #1;
      if (s_ar_ready[1] !== 1'b0) begin $display("FAIL ar_limit got=%b exp=0", s_ar_ready[1]); failures++; end
      checks++;
      tick();
      m_r_valid[1] = 1; m_r_last[1] = 1; m_r_data[1] = 8'hC5; #1;
      if (s_ar_ready[1] !== 1'b0 || m_r_ready[1] !== 1'b1) begin
         $display("FAIL ar_hold got=%b/%b exp=0/1", s_ar_ready[1], m_r_ready[1]); failures++;
      end
      checks++;
      tick();
      m_r_valid[1] = 0; m_r_last[1] = 0; #1;
      if ({s_r_valid[1], s_r_last[1], s_r_data[1], s_ar_ready[1]} !== {2'b11, 8'hC5, 1'b0}) begin
         $display("FAIL r_out got=%b/%b/%h/%b exp=1/1/c5/0", s_r_valid[1], s_r_last[1], s_r_data[1], s_ar_ready[1]);
         failures++;
      end
      checks++;
      $display("r: beat %h last=%b", s_r_data[1], s_r_last[1]);
      tick(); #1;
      if (s_ar_ready[1] !== 1'b1) begin $display("FAIL ar_after_r got=%b exp=1", s_ar_ready[1]); failures++; end
      checks++;
      tick(); #1;
      if (s_ar_ready[1] !== 1'b0) begin $display("FAIL ar_relimit got=%b exp=0", s_ar_ready[1]); failures++; end
      checks++;
      if (m_ar_valid[1] !== 1'b1 || m_ar_data[1] !== 8'hB2) begin
         $display("FAIL ar_third_out got=%b/%h exp=1/b2", m_ar_valid[1], m_ar_data[1]); failures++;
      end
      checks++;
      s_ar_valid[1] = 0;
   endtask

   task automatic test_isolate();
      do_reset();
      s_aw_valid[0] = 1; s_aw_data[0] = 8'hD0; #1;
      if (s_aw_ready[0] !== 1'b1) begin $display("FAIL iso_aw_first got=%b exp=1", s_aw_ready[0]); failures++; end
      checks++;
      tick();
      s_aw_valid[0] = 0; isolate[0] = 1; #1;
      if (s_aw_ready[0] !== 1'b1 || isolated[0] !== 1'b0) begin
         $display("FAIL iso_same_cycle got=%b/%b exp=1/0", s_aw_ready[0], isolated[0]); failures++;
      end
      checks++;
      tick();
      s_aw_valid[0] = 1; s_aw_data[0] = 8'hD1; #1;
      if (s_aw_ready[0] !== 1'b0 || isolated[0] !== 1'b0) begin
         $display("FAIL iso_aw_blocked got=%b/%b exp=0/0", s_aw_ready[0], isolated[0]); failures++;
      end
      checks++;
      m_b_valid[0] = 1; m_b_data[0] = 2'b01;
      tick();
      m_b_valid[0] = 0; #1;
      if ({s_b_valid[0], s_b_data[0], isolated[0]} !== 4'b1010) begin
         $display("FAIL iso_b_out got=%b/%b/%b exp=1/01/0", s_b_valid[0], s_b_data[0], isolated[0]); failures++;
      end
      checks++;
      $display("b: resp %b", s_b_data[0]);
      tick(); #1;
      if ({isolated[0], s_aw_ready[0], m_aw_valid[0]} !== 3'b100) begin
         $display("FAIL iso_isolated got=%b exp=100", {isolated[0], s_aw_ready[0], m_aw_valid[0]}); failures++;
      end
      checks++;
      isolate[0] = 0;
      tick(); #1;
      if (isolated[0] !== 1'b0 || s_aw_ready[0] !== 1'b1) begin
         $display("FAIL iso_release got=%b/%b exp=0/1", isolated[0], s_aw_ready[0]); failures++;
      end
      checks++;
      tick();
      s_aw_valid[0] = 0; #1;
      if (m_aw_valid[0] !== 1'b1 || m_aw_data[0] !== 8'hD1) begin
         $display("FAIL iso_aw_resume got=%b/%h exp=1/d1", m_aw_valid[0], m_aw_data[0]); failures++;
      end
      checks++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      m_aw_ready[0] = 0;
      s_aw_valid[0] = 1; s_aw_data[0] = 8'hEE;
      tick();
      s_aw_valid[0] = 0;
      rst_n = 0; #1;
      if (m_aw_valid[0] !== 1'b0 || s_aw_ready[0] !== 1'b1 || $isunknown(m_aw_data[0])) begin
         $display("FAIL reset_mid got=%b/%b/%h exp=0/1/known", m_aw_valid[0], s_aw_ready[0], m_aw_data[0]);
         failures++;
      end
      checks++;
      tick();
      rst_n = 1;
      tick(); #1;
      if (m_aw_valid[0] !== 1'b0) begin $display("FAIL reset_mid_after got=%b exp=0", m_aw_valid[0]); failures++; end
      checks++;
   endtask

`ifdef AXI_FIFO_CUT_STATS_EN
   task automatic test_stats();
      do_reset();
      m_w_ready[0] = 0;
      s_w_valid[0] = 1; s_w_data[0] = 8'h55; #1;
      if (stall_cnt[0] !== 32'd0) begin $display("FAIL stall_start got=%0d exp=0", stall_cnt[0]); failures++; end
      checks++;
      for (int i = 0; i < 6; i++) tick();
      #1;
      if (stall_cnt[0] !== 32'd5) begin $display("FAIL stall_five got=%0d exp=5", stall_cnt[0]); failures++; end
      checks++;
      s_w_valid[0] = 0;
   endtask
`endif

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 0;
      idle_all();
      test_reset();
      test_aw_backpressure();
      test_w_throughput(0, 8);
      test_w_throughput(1, 5);
      test_ar_limit();
      test_isolate();
      test_reset_mid();
`ifdef AXI_FIFO_CUT_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
